// File: rtl/cordic_pkg.sv
// cordic_pkg: constants, state type and arctangent quantiser shared by the CORDIC blocks
//   ATAN_TABLE : atan(2^-i)/(pi/2) scaled by 2^32, rounded
//   K_INV      : 1/K scaled by 2^16, removes the CORDIC gain from the magnitude
//   atan_q     : ATAN_TABLE[i] rounded to frac fractional bits (pi/2 = 2^frac)
package cordic_pkg;

  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'd2147483648, 32'd1267733622, 32'd669835629, 32'd340019024,
    32'd170669324,  32'd85417861,   32'd42719353,  32'd21360980,
    32'd10680653,   32'd5340347,    32'd2670176,   32'd1335088,
    32'd667544,     32'd333772,     32'd166886,    32'd83443,
    32'd41722,      32'd20861,      32'd10430,     32'd5215,
    32'd2608,       32'd1304,       32'd652,       32'd326,
    32'd163,        32'd81,         32'd41,        32'd20,
    32'd10,         32'd5,          32'd3,         32'd1
  };

  localparam logic [15:0] K_INV = 16'd39797;

  typedef enum logic [1:0] {IDLE, ROTATE, SCALE} cordic_state_t;

  function automatic logic [63:0] atan_q(input logic [4:0] i, input int frac);
    logic [63:0] t;
    t = {32'd0, ATAN_TABLE[i]};
    return frac >= 32 ? t << (frac - 32) : (t + (64'd1 << (31 - frac))) >> (32 - frac);
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation driving y towards zero
//   x, y, z : current vector and accumulated angle (pi/2 = 2^ZFRAC)
//   i       : iteration index, selects shift and arctangent
//   xn, yn, zn : rotated vector and updated angle
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int XW    = 15,
  parameter int ZW    = 12,
  parameter int ZFRAC = 10
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic [4:0]           i,
  output logic signed [XW-1:0] xn,
  output logic signed [XW-1:0] yn,
  output logic signed [ZW-1:0] zn
);

  logic signed [XW-1:0] xs, ys;
  logic signed [ZW-1:0] a;

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    a  = ZW'(atan_q(i, ZFRAC));
    xn = y[XW-1] ? x - ys : x + ys;
    yn = y[XW-1] ? y + xs : y - xs;
    zn = y[XW-1] ? z - a : z + a;
  end

endmodule

// File: rtl/cordic_vec.sv
// cordic_vec: iterative CORDIC vectoring, quadrant-I (x, y) to angle and magnitude
//   clk, reset      : clock, asynchronous active-high reset
//   start           : begin an operation, accepted only while done=1
//   in_x, in_y      : unsigned operands, sampled on an accepted start
//   angle           : atan2(y, x), pi/4 = 2^(ANGLE_WIDTH-1), pi/2 saturates to all ones
//   magnitude       : gain-compensated sqrt(x^2 + y^2)
//   done            : idle with outputs valid
module cordic_vec
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ANGLE_WIDTH = 8,
  parameter int ITERATIONS  = ANGLE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  in_x,
  input  logic [DATA_WIDTH-1:0]  in_y,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic [DATA_WIDTH:0]    magnitude,
  output logic                   done
);

  // Fractional guard bits below the operand LSB keep the truncating shifts
  // from inflating x; without them the magnitude drifts by several LSBs.
  localparam int GUARD = 4;
  localparam int XW    = DATA_WIDTH + 3 + GUARD;
  // Angle carries 2 guard bits (pi/2 = 2^(ANGLE_WIDTH+2)); the sum of all
  // arctangents reaches ~1.11*pi/2, so one extra bit plus sign is needed.
  localparam int ZW    = ANGLE_WIDTH + 4;
  localparam int PW    = XW + 16;

  cordic_state_t state, state_n;

  logic signed [XW-1:0] x, y, xn, yn;
  logic signed [ZW-1:0] z, zn, zr;
  logic [4:0]           cnt;
  logic                 zero, yaxis, last;
  logic [PW-1:0]        prod, mag_full;
  logic [ANGLE_WIDTH-1:0] ang_n;
  logic [DATA_WIDTH:0]    mag_n;

  cordic_vec_stage #(.XW(XW), .ZW(ZW), .ZFRAC(ANGLE_WIDTH + 2)) u_stage (
    .x (x),
    .y (y),
    .z (z),
    .i (cnt),
    .xn(xn),
    .yn(yn),
    .zn(zn)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    last    = cnt == 5'(ITERATIONS - 1);
    state_n = state == IDLE   ? (start ? ROTATE : IDLE) :
              state == ROTATE ? (last ? SCALE : ROTATE) : IDLE;
  end

  // Result formatting: round away the angle guard bits, clamp into range,
  // and scale x by 1/K with round-half-up before saturating.
  always_comb begin
    zr       = (z + $signed(ZW'(2))) >>> 2;
    ang_n    = zr[ZW-1] ? '0 : |zr[ZW-2:ANGLE_WIDTH] ? '1 : zr[ANGLE_WIDTH-1:0];
    prod     = PW'($unsigned(x)) * PW'(K_INV);
    mag_full = (prod + (PW'(1) << (15 + GUARD))) >> (16 + GUARD);
    mag_n    = |mag_full[PW-1:DATA_WIDTH+1] ? '1 : mag_full[DATA_WIDTH:0];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      cnt       <= '0;
      zero      <= 1'b0;
      yaxis     <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
      done      <= 1'b1;
    end else begin
      if (state == IDLE && start) begin
        x     <= {3'b000, in_x, {GUARD{1'b0}}};
        y     <= {3'b000, in_y, {GUARD{1'b0}}};
        z     <= '0;
        cnt   <= '0;
        zero  <= in_x == '0 && in_y == '0;
        yaxis <= in_x == '0 && in_y != '0;
        done  <= 1'b0;
      end
      if (state == ROTATE) begin
        x   <= xn;
        y   <= yn;
        z   <= zn;
        cnt <= cnt + 5'd1;
      end
      // Degenerate inputs are forced rather than trusted to the iterations.
      if (state == SCALE) begin
        angle     <= zero ? '0 : yaxis ? '1 : ang_n;
        magnitude <= zero ? '0 : mag_n;
        done      <= 1'b1;
      end
    end

endmodule

// File: tb/tb_cordic_vec.sv
// tb_cordic_vec: directed and randomised self-checking bench for cordic_vec
module tb_cordic_vec;

  logic       clk, reset, start, done;
  logic [7:0] in_x, in_y, angle;
  logic [8:0] magnitude;
  int         errors = 0;
  int         checks = 0;
  int         n;
  localparam real PI = 3.14159265358979;

  cordic_vec #(.DATA_WIDTH(8), .ANGLE_WIDTH(8), .ITERATIONS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_x     (in_x),
    .in_y     (in_y),
    .angle    (angle),
    .magnitude(magnitude),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic chkr(input string tag, input int got, input real want, input real tol);
    real d;
    checks++;
    d = got - want;
    if (d < 0.0) d = -d;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0.2f +/- %0.1f", tag, got, want, tol);
    end
  endtask

  task automatic launch(input int x, input int y);
    in_x  = 8'(x);
    in_y  = 8'(y);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL timeout: done got 0, expected 1 within 50 cycles");
    end
  endtask

  initial begin
    int t[3];
    int k;
    logic prev;
    reset = 1'b1;
    start = 1'b0;
    in_x  = '0;
    in_y  = '0;
    repeat (2) tick();
    chk("rst_done", int'(done), 1, 1);
    chk("rst_angle", int'(angle), 0, 0);
    chk("rst_mag", int'(magnitude), 0, 0);
    reset = 1'b0;
    tick();

    launch(100, 0);
    chk("done_fall", int'(done), 0, 0);
    wait_done(n);
    chk("latency", n, 9, 9);
    chk("x_axis_angle", int'(angle), 0, 1);
    chk("x_axis_mag", int'(magnitude), 99, 101);

    launch(100, 100);
    wait_done(n);
    chk("diag_angle", int'(angle), 127, 129);
    chk("diag_mag", int'(magnitude), 140, 142);

    launch(221, 128);
    wait_done(n);
    chk("mid_angle", int'(angle), 85, 86);
    chk("mid_mag", int'(magnitude), 254, 256);

    launch(0, 100);
    wait_done(n);
    chk("y_axis_angle", int'(angle), 255, 255);
    chk("y_axis_mag", int'(magnitude), 99, 101);

    launch(0, 0);
    wait_done(n);
    chk("zero_angle", int'(angle), 0, 0);
    chk("zero_mag", int'(magnitude), 0, 0);

    launch(255, 255);
    wait_done(n);
    chk("max_angle", int'(angle), 127, 129);
    chk("max_mag", int'(magnitude), 360, 362);

    launch(100, 100);
    repeat (3) tick();
    in_x  = 8'd10;
    in_y  = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_hold_mag", int'(magnitude), 360, 362);
    chk("busy_done", int'(done), 0, 0);
    wait_done(n);
    chk("busy_angle", int'(angle), 127, 129);
    chk("busy_mag", int'(magnitude), 140, 142);
    repeat (3) tick();
    chk("no_second_op", int'(done), 1, 1);

    launch(100, 100);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_done", int'(done), 1, 1);
    chk("abort_angle", int'(angle), 0, 0);
    chk("abort_mag", int'(magnitude), 0, 0);
    tick();
    reset = 1'b0;
    tick();
    launch(50, 50);
    wait_done(n);
    chk("after_abort_angle", int'(angle), 127, 129);
    chk("after_abort_mag", int'(magnitude), 70, 72);

    in_x  = 8'd100;
    in_y  = 8'd0;
    start = 1'b1;
    k     = 0;
    prev  = done;
    for (int c = 0; c < 40 && k < 3; c++) begin
      tick();
      if (done && !prev) begin
        t[k] = c;
        k++;
      end
      prev = done;
    end
    start = 1'b0;
    chk("hold_count", k, 3, 3);
    chk("hold_gap1", t[1] - t[0], 10, 10);
    chk("hold_gap2", t[2] - t[1], 10, 10);
    chk("hold_mag", int'(magnitude), 99, 101);

    for (int i = 0; i < 20; i++) begin
      int  rx, ry;
      real ea, em;
      rx = int'($urandom_range(1, 255));
      ry = int'($urandom_range(0, 255));
      launch(rx, ry);
      wait_done(n);
      ea = $atan2(real'(ry), real'(rx)) * 512.0 / PI;
      if (ea > 255.0) ea = 255.0;
      em = $sqrt(real'(rx * rx + ry * ry));
      chkr($sformatf("rand_angle_%0d_%0d", rx, ry), int'(angle), ea, 2.0);
      chkr($sformatf("rand_mag_%0d_%0d", rx, ry), int'(magnitude), em, 1.5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
